// File: rtl/serial_sub_pkg.sv
// +----------------------------------------------------------------------+
// | serial_sub_pkg: shared FSM state type and sizing helper for the       |
// | bit-serial subtractor.                                                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +----------------------------------------------------------------------+
// | full_subtractor: combinational one-bit cell computing x - y - bin.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  assign d1 = x ^ y;
  assign b1 = ~x & y;
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;
  assign bo = b1 | b2;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------+
// | serial_subtractor: LSB-first bit-serial A - B with start/busy/done.   |
// | Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the first WIDTH-1 difference bits; the last bit comes straight from the cell.
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_step;

  full_subtractor u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sr   <= a;
      b_sr   <= b;
      borrow <= 1'b0;
    end else if (state == SHIFT) begin
      cnt    <= cnt + CW'(1);
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {cell_d, res_sr[WIDTH-2:1]};
      borrow <= cell_bo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_step) begin
      diff <= {cell_d, res_sr};
      bout <= cell_bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_step) begin
      // cell_d is the result MSB on the final step.
      ovf <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------+
// | tb_serial_subtractor: scoreboard bench for serial_subtractor.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             ovf;
    logic             bout;
    logic [WIDTH-1:0] diff;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t e;
    e.diff = av - bv;
    e.bout = (av < bv);
    e.ovf  = (av[WIDTH-1] != bv[WIDTH-1]) && (e.diff[WIDTH-1] != av[WIDTH-1]);
    return e;
  endfunction

  // Scoreboard consumer: one expected entry per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.diff});
        check("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Entered at posedge+1 in IDLE; returns at posedge+1 after the done cycle.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int ign_at);
    int lat;
    int n_busy;
    int changes;
    logic [WIDTH-1:0] d0;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(model(av, bv));
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0; n_busy = 0; changes = 0; d0 = diff;
    while (!done && lat < 40) begin
      if (busy) n_busy++;
      if (diff !== d0) changes++;
      if (lat == ign_at) begin
        a = 8'hFF; b = 8'h00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, WIDTH);
    check("busy_cycles", n_busy, WIDTH);
    check("diff_stable_in_shift", changes, 0);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_times[$];
    int changes;
    logic [WIDTH-1:0] d0;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h5A, 8'h23, -1);
    do_op(8'h10, 8'h20, -1);
    do_op(8'h00, 8'h00, -1);
    do_op(8'h00, 8'h01, -1);
    do_op(8'hFF, 8'h01, -1);
`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, -1);
    do_op(8'h7F, 8'hFF, -1);
    do_op(8'h05, 8'h03, -1);
`endif

    // start pulsed mid-SHIFT must be ignored, with no queued operation afterwards.
    do_op(8'h5A, 8'h23, 3);
    changes = 0;
    repeat (12) begin
      if (done || busy) changes++;
      @(posedge clk); #1;
    end
    check("no_queued_op", changes, 0);

    // Asynchronous reset in the middle of SHIFT.
    a = 8'h5A; b = 8'h23; start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h23));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
    void'(exp_q.pop_back());
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h09, 8'h04, -1);

    // start held high: back-to-back operations.
    a = 8'h03; b = 8'h01; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(8'h03, 8'h01));
    changes = 0; d0 = diff;
    for (int t = 0; t < 60 && done_times.size() < 3; t++) begin
      @(posedge clk); #1;
      if (diff !== d0) changes++;
      d0 = diff;
      if (done) done_times.push_back(t);
    end
    start = 1'b0;
    check("b2b_count", done_times.size(), 3);
    if (done_times.size() == 3) begin
      check("b2b_spacing1", done_times[1] - done_times[0], WIDTH + 2);
      check("b2b_spacing2", done_times[2] - done_times[1], WIDTH + 2);
    end
    check("b2b_diff_changes", changes, 1);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B, LSB first, one bit per clock, through a single full-subtractor cell with a registered borrow. It is the subtraction counterpart of the team's ripple full-adder datapath. It serves area-constrained control paths where latency is acceptable. Operands are accepted with a start/busy/done handshake, and the result is held until the next accepted start.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; sampled on the accepting edge.
- b  in  WIDTH  subtrahend; sampled on the accepting edge.
- busy  out  1  high while bits are being processed (SHIFT state).
- done  out  1  one-cycle pulse; diff and bout are valid from this cycle on.
- diff  out  WIDTH  A − B modulo 2^WIDTH.
- bout  out  1  final borrow; 1 iff unsigned A < B.
- ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States and transitions:
  - IDLE → SHIFT on start.
  - SHIFT → DONE after WIDTH bit-steps.
  - DONE → IDLE unconditionally.
- Accept, on the clock edge in IDLE with start=1:
  - load a and b into shift registers;
  - clear the borrow register;
  - clear the bit counter.
- Each SHIFT edge:
  - feed a_sr[0], b_sr[0] and the borrow register into the full subtractor;
  - shift the difference bit into the MSB of the result register; after WIDTH steps bit 0 is the LSB;
  - shift a_sr and b_sr right by one;
  - load the borrow register with the cell's borrow-out;
  - increment the counter.
- Full-subtractor cell:
  - d1 = x ^ y, b1 = ~x & y;
  - d = d1 ^ bin, b2 = ~d1 & bin;
  - bo = b1 | b2.
- On entry to DONE: diff = result register, bout = borrow register. Both hold until the next accept.
- diff and bout do not change during SHIFT. The shift register is internal, and outputs update only on SHIFT→DONE.
- start is ignored in SHIFT and DONE; no queuing.
- a and b may change freely after the accept edge.
- Reset at any time, including mid-SHIFT, forces IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, borrow=0, counter=0. The partial result is discarded.

## Timing
- Accept edge = E0. busy is high after E0 through the cycle ending at edge E(WIDTH).
- done is high for exactly the one cycle after E(WIDTH). busy is 0 in that cycle.
- Latency from accept edge to done: WIDTH+1 rising edges after E0 until the done cycle ends; done is visible WIDTH cycles after E0.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is on the edge after the done cycle, in IDLE.
- Reset values of all outputs: 0.
- start held high continuously produces back-to-back operations spaced WIDTH+2 cycles apart.

## Configuration
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port exists;
  - ovf = (a[WIDTH-1] ≠ b[WIDTH-1]) & (diff[WIDTH-1] ≠ a[WIDTH-1]), computed from the latched operand MSBs;
  - ovf updates with diff on SHIFT→DONE and holds until the next accept.
- Not defined: no ovf port, no MSB capture registers. All other behaviour is identical.

## Structure
- Package serial_sub_pkg:
  - state enum: IDLE, SHIFT, DONE;
  - counter-width helper function $clog2(WIDTH+1).
- One sub-module: full_subtractor, purely combinational, implementing the cell equations above.
- Top-level content: FSM, counter, shift registers, borrow flop, output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, start one cycle → done exactly 8 cycles after the accept edge; diff=0x37, bout=0; busy high for 8 cycles.
- a=0x10, b=0x20 → diff=0xF0, bout=1; a=0x00, b=0x00 → diff=0x00, bout=0; a=0x00, b=0x01 → diff=0xFF, bout=1.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1;
  - a=0x7F, b=0xFF → diff=0x80, ovf=1;
  - a=0x05, b=0x03 → ovf=0.
- Accept a=0x5A, b=0x23, then pulse start with a=0xFF, b=0x00 at SHIFT cycle 3 → ignored; result 0x37; next done only after a new start in IDLE.
- Accept, then assert rst_n=0 at SHIFT cycle 4 → all outputs 0 asynchronously. After release, a=0x09, b=0x04 → diff=0x05, bout=0; no stale borrow.
- start held high, a=0x03, b=0x01 → done pulses every 10 cycles, diff=0x02 each time; diff stable between pulses.
